// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one APU/FPU between NUM_CORES cores, with in-order result routing.
// Optional: define CV32E40P_APU_ARB_STALL_CNT_EN to add per-core saturating stall counters (stall_cnt_o).
module cv32e40p_apu_arbiter #(
    parameter int NUM_CORES        = 4,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int APU_NARGS_CPU    = 3,
    parameter int APU_WOP_CPU      = 6,
    parameter int APU_NDSFLAGS_CPU = 15,
    parameter int APU_NUSFLAGS_CPU = 5
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [NUM_CORES-1:0]                          core_req_i,
    output logic [NUM_CORES-1:0]                          core_gnt_o,
    input  logic [NUM_CORES-1:0][APU_NARGS_CPU-1:0][31:0] core_operands_i,
    input  logic [NUM_CORES-1:0][APU_WOP_CPU-1:0]         core_op_i,
    input  logic [NUM_CORES-1:0][APU_NDSFLAGS_CPU-1:0]    core_flags_i,
    output logic [NUM_CORES-1:0]                          core_rvalid_o,
    output logic [31:0]                                   core_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]                   core_rflags_o,
    output logic [NUM_CORES-1:0]                          core_busy_o,
    output logic                                          fpu_req_o,
    input  logic                                          fpu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]                fpu_operands_o,
    output logic [APU_WOP_CPU-1:0]                        fpu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]                   fpu_flags_o,
    input  logic                                          fpu_rvalid_i,
    input  logic [31:0]                                   fpu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]                   fpu_rflags_i,
    output logic                                          fpu_clk_en_o,
    output logic                                          err_o
`ifdef CV32E40P_APU_ARB_STALL_CNT_EN
    ,
    output logic [NUM_CORES-1:0][15:0]                    stall_cnt_o
`endif
);

    localparam int IDW = $clog2(NUM_CORES);
    localparam int IW1 = IDW + 1;
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t                          r_state, w_state_nxt;
    logic [IDW-1:0]                  r_winner, r_rr_ptr;
    logic [IDW-1:0]                  w_rr_sel, w_sel, w_head;
    logic [IW1-1:0]                  w_idx;
    logic                            w_rr_found, w_valid, w_accept, w_pop, w_err_set;
    logic [IDW-1:0]                  r_fifo [MAX_OUTSTANDING];
    logic [PW-1:0]                   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]                   r_count;
    logic [NUM_CORES-1:0][CW-1:0]    r_inflight;
    logic                            r_err;

    // First requester at or after rr_ptr, searching circularly.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_sel   = r_rr_ptr;
        w_idx      = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_idx = {1'b0, r_rr_ptr} + IW1'(k);
            if (w_idx >= IW1'(NUM_CORES)) w_idx = w_idx - IW1'(NUM_CORES);
            if (!w_rr_found && core_req_i[w_idx[IDW-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_sel   = w_idx[IDW-1:0];
            end
        end
    end

    assign w_sel     = (r_state == S_LOCKED) ? r_winner : w_rr_sel;
    assign w_valid   = (r_state == S_LOCKED) ? core_req_i[r_winner] : w_rr_found;
    assign fpu_req_o = w_valid && (r_count < CW'(MAX_OUTSTANDING));
    assign w_accept  = fpu_req_o && fpu_gnt_i;
    assign w_head    = r_fifo[r_rd_ptr];
    assign w_pop     = fpu_rvalid_i && (r_count != '0);

    // A dropped request from the locked winner, or a response with nothing in flight.
    assign w_err_set = ((r_state == S_LOCKED) && !core_req_i[r_winner]) ||
                       (fpu_rvalid_i && (r_count == '0));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (fpu_req_o && !fpu_gnt_i) w_state_nxt = S_LOCKED;
            S_LOCKED: if (!core_req_i[r_winner] || fpu_gnt_i) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_winner <= '0;
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= r_err | w_err_set;
            if (r_state == S_IDLE && fpu_req_o && !fpu_gnt_i) r_winner <= w_sel;
            if (w_accept)
                r_rr_ptr <= (w_sel == IDW'(NUM_CORES - 1)) ? '0 : w_sel + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
        end else begin
            if (w_accept) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr <= (r_wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + 1'b1;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            for (int i = 0; i < NUM_CORES; i++) begin
                case ({w_accept && (w_sel == IDW'(i)), w_pop && (w_head == IDW'(i))})
                    2'b10:   r_inflight[i] <= r_inflight[i] + 1'b1;
                    2'b01:   r_inflight[i] <= r_inflight[i] - 1'b1;
                    default: r_inflight[i] <= r_inflight[i];
                endcase
            end
        end
    end

    always_comb begin
        core_gnt_o    = '0;
        core_rvalid_o = '0;
        core_busy_o   = '0;
        if (w_accept) core_gnt_o[w_sel] = 1'b1;
        if (w_pop)    core_rvalid_o[w_head] = 1'b1;
        for (int i = 0; i < NUM_CORES; i++) core_busy_o[i] = (r_inflight[i] != '0);
    end

    // Payload is gated so an idle arbiter presents an all-zero request.
    assign fpu_operands_o = w_valid ? core_operands_i[w_sel] : '0;
    assign fpu_op_o       = w_valid ? core_op_i[w_sel]       : '0;
    assign fpu_flags_o    = w_valid ? core_flags_i[w_sel]    : '0;
    assign core_result_o  = fpu_result_i;
    assign core_rflags_o  = fpu_rflags_i;
    assign fpu_clk_en_o   = fpu_req_o | (r_count != '0);
    assign err_o          = r_err;

`ifdef CV32E40P_APU_ARB_STALL_CNT_EN
    logic [NUM_CORES-1:0][15:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++)
                if (core_req_i[i] && !core_gnt_o[i] && (r_stall_cnt[i] != 16'hFFFF))
                    r_stall_cnt[i] <= r_stall_cnt[i] + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: doc/cv32e40p_apu_arbiter.md
# cv32e40p_apu_arbiter

Shares one APU/FPU datapath between up to NUM_CORES CV32E40P cores in a cluster. The arbiter sits between the cores' APU request ports and a single FPU wrapper instance. It selects one requester per accepted operation with round-robin fairness and holds the selection stable until the FPU grants it. It records the requester ID of every accepted operation and routes each in-order result back to its originator. It also drives the enable for the shared FPU clock gate.

## Interface
Parameters:
- NUM_CORES, default 4: number of requesting cores, 2..16.
- MAX_OUTSTANDING, default 4: depth of the requester-ID FIFO, which bounds the number of in-flight FPU operations; power of two, at least 1.
- Operand, op, flag and result widths come from the core's APU package constants: APU_NARGS_CPU, APU_WOP_CPU, APU_NDSFLAGS_CPU, APU_NUSFLAGS_CPU.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; asynchronous, active-high.
- core_req_i  in  NUM_CORES  per-core APU request.
- core_gnt_o  out  NUM_CORES  per-core grant; one-hot or zero.
- core_operands_i  in  NUM_CORES x APU_NARGS_CPU x 32  per-core operands.
- core_op_i  in  NUM_CORES x APU_WOP_CPU  per-core opcode.
- core_flags_i  in  NUM_CORES x APU_NDSFLAGS_CPU  per-core request flags.
- core_rvalid_o  out  NUM_CORES  per-core result valid; one-hot or zero.
- core_result_o  out  32  result, broadcast to all cores.
- core_rflags_o  out  APU_NUSFLAGS_CPU  result flags, broadcast to all cores.
- core_busy_o  out  NUM_CORES  core has at least one operation in flight.
- fpu_req_o / fpu_gnt_i  out / in  1  request and grant toward the FPU wrapper.
- fpu_operands_o, fpu_op_o, fpu_flags_o  out  package widths  muxed request payload.
- fpu_rvalid_i, fpu_result_i, fpu_rflags_i  in  1 / 32 / APU_NUSFLAGS_CPU  FPU response.
- fpu_clk_en_o  out  1  enable for the FPU clock gate.
- err_o  out  1  sticky protocol error.

## Operation
- FSM states:
  - IDLE: the winner is the first requesting core at or after rr_ptr, in circular order.
  - LOCKED: entered when fpu_req_o=1 and fpu_gnt_i=0. The winner register holds, and the payload mux follows that register.
  - LOCKED returns to IDLE on fpu_gnt_i.
- fpu_req_o = (a requester is selected) and (fifo_count < MAX_OUTSTANDING). fifo_count is the registered count, so a pop in the same cycle does not free a slot until the next cycle.
- Accept occurs when fpu_req_o and fpu_gnt_i are both high. On accept:
  - core_gnt_o[winner] = 1;
  - the winner ID is pushed into the FIFO;
  - rr_ptr = winner+1, mod NUM_CORES.
- In LOCKED, a deasserted core_req_i from the locked winner is a protocol error: set err_o and return to IDLE.
- Response: on fpu_rvalid_i, the FIFO head is popped, core_rvalid_o[head]=1, and result/flags pass through combinationally. The FPU must return results in issue order.
- fpu_rvalid_i with an empty FIFO sets err_o and is otherwise ignored.
- Push and pop in the same cycle: fifo_count is unchanged and both pointers advance. Pointers wrap modulo MAX_OUTSTANDING.
- core_busy_o[i] = 1 while any FIFO entry equals i. It is kept as a per-core in-flight counter of width clog2(MAX_OUTSTANDING+1).
- fpu_clk_en_o = fpu_req_o | (fifo_count != 0).
- Reset values: FSM IDLE, rr_ptr=0, FIFO empty, all counters 0, err_o=0. With no inputs active, every output is 0.
- Reset mid-operation drops in-flight IDs. The FPU wrapper must be reset in the same cycle.

## Timing
- Arbitration: 0 cycles. A request in IDLE drives fpu_req_o in the same cycle.
- core_gnt_o is combinational from fpu_gnt_i.
- Result: core_rvalid_o is combinational from fpu_rvalid_i; the arbiter adds 0 cycles of latency.
- Payload on fpu_* is stable from the first fpu_req_o cycle until accept.
- Fairness: a continuously requesting core is accepted within NUM_CORES-1 accepts for other cores.
- Back-to-back accepts are allowed, one per cycle, while the FIFO is not full.

## Configuration
- CV32E40P_APU_ARB_STALL_CNT_EN defined:
  - adds output stall_cnt_o [NUM_CORES x 16];
  - each counter increments every cycle core_req_i[i]=1 && core_gnt_o[i]=0;
  - counters saturate at 0xFFFF and reset to 0.
- Macro undefined: the port and the counters are absent. Behaviour is otherwise identical.

## Test plan
- Single requester: core 2 requests, FPU grants in the same cycle → core_gnt_o=4'b0100 in cycle 0, core_busy_o[2]=1. fpu_rvalid_i 3 cycles later → core_rvalid_o=4'b0100 with result 0x3F800000 passed through, then busy clears.
- Round robin: cores 0..3 request continuously, fpu_gnt_i=1 always → accept order 0,1,2,3,0, one per cycle.
- Lock: core 1 wins, fpu_gnt_i held low for 5 cycles while core 0 also requests → fpu_op_o stays core 1's op for all 5 cycles, and the grant goes to core 1.
- Full FIFO (MAX_OUTSTANDING=4): 4 accepts with no responses → fpu_req_o=0 while requests are pending. One rvalid → fpu_req_o=1 in the next cycle, not the same cycle.
- Errors: fpu_rvalid_i with the FIFO empty → err_o=1 next cycle and sticky, no core_rvalid_o. Assert rst_i mid-flight → all outputs 0 and err_o=0.
